// File: rtl/mux_pkg.sv
// Shared definitions for the parametrised mux family: mode encodings and a
// clog2 helper that never returns a zero width.
package mux_pkg;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_MAN  = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// Auto-scan channel sequencer: dwell counter plus wrapping channel index,
// zeroed when the owning mux changes mode.
module mux_scan_counter
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SELW = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            restart,
  output logic [SELW-1:0] idx,
  output logic            first
);

  localparam int unsigned DWW = clog2_min1(DWELL + 1);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N_CH - 1);
  localparam logic [DWW-1:0]  DWELL_W  = DWW'(DWELL);

  logic [SELW-1:0] idx_q, idx_d, idx_cur;
  logic [DWW-1:0]  cnt_q, cnt_d, cnt_cur, cnt_inc;

  // A restart applies to the same load that triggers it, so the current
  // position is overridden combinationally rather than one cycle later.
  always_comb begin
    idx_cur = restart ? '0 : idx_q;
    cnt_cur = restart ? '0 : cnt_q;
    cnt_inc = cnt_cur + DWW'(1);
    idx_d   = idx_cur;
    cnt_d   = cnt_cur;
    if (step) begin
      if (cnt_inc == DWELL_W) begin
        cnt_d = '0;
        idx_d = (idx_cur == LAST_IDX) ? '0 : idx_cur + SELW'(1);
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx   = idx_cur;
  assign first = (idx_cur == '0) && (cnt_cur == '0);

endmodule

// File: rtl/mux_tdm_scanner.sv
// N-channel registered mux with auto TDM scan or manual select, presenting
// one sample at a time on a valid/ready output.
module mux_tdm_scanner
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SELW = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel_man,
  output logic [WIDTH-1:0]      y,
  output logic [SELW-1:0]       y_ch,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  frame_start,
  output logic                  sel_err
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(N_CH - 1);
  localparam logic [SELW:0]   NCH_W    = (SELW + 1)'(N_CH);

  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_data[k] = d[k*WIDTH +: WIDTH];
  end

  logic            load, auto, restart, step, first, sel_bad, mode_q;
  logic [SELW-1:0] scan_idx, sel;

  assign load    = en && (!y_valid || y_ready);
  assign auto    = (mode == MODE_AUTO);
  // mode_q only moves on loads, so a mode flip during a stall is seen at the
  // first load after it.
  assign restart = load && (mode != mode_q);
  assign step    = load && auto;

  mux_scan_counter #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .restart (restart),
    .idx     (scan_idx),
    .first   (first)
  );

  always_comb begin
    sel_bad = 1'b0;
    sel     = scan_idx;
    if (!auto) begin
      sel_bad = ({1'b0, sel_man} >= NCH_W);
      sel     = sel_bad ? LAST_IDX : sel_man;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y           <= '0;
      y_ch        <= '0;
      y_valid     <= 1'b0;
      frame_start <= 1'b0;
      sel_err     <= 1'b0;
      mode_q      <= MODE_AUTO;
    end else if (load) begin
      y           <= ch_data[sel];
      y_ch        <= sel;
      y_valid     <= 1'b1;
      frame_start <= auto && first;
      sel_err     <= sel_bad;
      mode_q      <= mode;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_tdm_scanner.sv
// Scoreboard bench: a 4-channel/dwell-1 and a 3-channel/dwell-2 instance run
// side by side against a behavioural model of the scanner.
module tb_mux_tdm_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] d4;
  logic        en4, mode4, rdy4;
  logic [1:0]  sm4, ch4;
  logic [7:0]  y4;
  logic        v4, fs4, err4;

  logic [23:0] d3;
  logic        en3, mode3, rdy3;
  logic [1:0]  sm3, ch3;
  logic [7:0]  y3;
  logic        v3, fs3, err3;

  mux_tdm_scanner #(.N_CH(4), .WIDTH(8), .DWELL(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .en(en4), .mode(mode4), .sel_man(sm4),
    .y(y4), .y_ch(ch4), .y_valid(v4), .y_ready(rdy4), .frame_start(fs4), .sel_err(err4)
  );

  mux_tdm_scanner #(.N_CH(3), .WIDTH(8), .DWELL(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .en(en3), .mode(mode3), .sel_man(sm3),
    .y(y3), .y_ch(ch3), .y_valid(v3), .y_ready(rdy3), .frame_start(fs3), .sel_err(err3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] ch;
    logic       fs;
    logic       err;
  } smp_t;

  typedef struct {
    int   idx;
    int   cnt;
    bit   mode_q;
    bit   valid;
  } mst_t;

  function automatic void model_step(input int nch, input int dwell, input bit en,
                                     input bit mode, input bit ready, input int selm,
                                     input logic [31:0] dv, input mst_t si,
                                     output mst_t so, output bit ld, output smp_t e);
    int ci, cc, sel;
    so = si;
    e  = '0;
    ld = en && (!si.valid || ready);
    if (ld) begin
      ci = (mode != si.mode_q) ? 0 : si.idx;
      cc = (mode != si.mode_q) ? 0 : si.cnt;
      if (!mode) begin
        sel  = ci;
        e.fs = (ci == 0 && cc == 0);
        cc++;
        if (cc == dwell) begin
          cc = 0;
          ci = (ci + 1) % nch;
        end
      end else begin
        e.err = (selm >= nch);
        sel   = e.err ? nch - 1 : selm;
      end
      e.y       = dv[sel*8 +: 8];
      e.ch      = 2'(sel);
      so.idx    = ci;
      so.cnt    = cc;
      so.mode_q = mode;
      so.valid  = 1'b1;
    end else if (si.valid && ready) begin
      so.valid = 1'b0;
    end
  endfunction

  smp_t q4[$], q3[$];
  mst_t s4, s3;
  bit   ld4, ld3;

  always @(posedge clk or negedge rst_n) begin
    mst_t ns;
    smp_t e;
    if (!rst_n) begin
      s4  = '{0, 0, 1'b0, 1'b0};
      s3  = '{0, 0, 1'b0, 1'b0};
      ld4 = 1'b0;
      ld3 = 1'b0;
      q4.delete();
      q3.delete();
    end else begin
      model_step(4, 1, en4, mode4, rdy4, int'(sm4), d4, s4, ns, ld4, e);
      s4 = ns;
      if (ld4) q4.push_back(e);
      model_step(3, 2, en3, mode3, rdy3, int'(sm3), {8'h00, d3}, s3, ns, ld3, e);
      s3 = ns;
      if (ld3) q3.push_back(e);
    end
  end

  always @(negedge clk) begin
    smp_t e;
    if (rst_n) begin
      if (ld4 && q4.size() > 0) begin
        e = q4.pop_front();
        check_eq("dut4.y", y4, e.y);
        check_eq("dut4.y_ch", ch4, e.ch);
        check_eq("dut4.frame_start", fs4, e.fs);
        check_eq("dut4.sel_err", err4, e.err);
      end
      if (ld3 && q3.size() > 0) begin
        e = q3.pop_front();
        check_eq("dut3.y", y3, e.y);
        check_eq("dut3.y_ch", ch3, e.ch);
        check_eq("dut3.frame_start", fs3, e.fs);
        check_eq("dut3.sel_err", err3, e.err);
      end
      check_eq("dut4.y_valid", v4, s4.valid);
      check_eq("dut3.y_valid", v3, s3.valid);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    d4 = 32'h44332211; en4 = 0; mode4 = 0; rdy4 = 1; sm4 = 0;
    d3 = 24'h332211;   en3 = 0; mode3 = 0; rdy3 = 1; sm3 = 0;
    tick(3);
    check_eq("rst.y", {y4, y3}, 16'h0);
    check_eq("rst.flags", {v4, fs4, err4, ch4, v3, fs3, err3, ch3}, 12'h0);
    rst_n = 1'b1;

    // Auto scan: 11,22,33,44,11,... checked by the scoreboard.
    en4 = 1;
    tick(5);
    check_eq("scan.wrap_y", y4, 32'h11);
    check_eq("scan.wrap_fs", fs4, 1);

    // Stall while 22 is presented.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (y4 == 8'h22) found = 1;
      else tick(1);
    end
    check_eq("stall.found22", found, 1);
    rdy4 = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("stall.hold_y", y4, 32'h22);
      check_eq("stall.hold_ch", ch4, 1);
      check_eq("stall.hold_v", v4, 1);
    end
    rdy4 = 1;
    tick(1);
    check_eq("stall.next", y4, 32'h33);

    // Dwell 2 over 3 channels.
    en3 = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_eq("dwell.in_range", ch3 < 2'd3, 1);
    end

    // Manual select.
    mode4 = 1; sm4 = 2;
    tick(1);
    check_eq("man.y33", y4, 32'h33);
    mode3 = 1; sm3 = 3;
    tick(1);
    check_eq("man.clamp_y", y3, 32'h33);
    check_eq("man.err_set", err3, 1);
    sm3 = 1;
    tick(1);
    check_eq("man.err_clr", err3, 0);
    check_eq("man.y22", y3, 32'h22);

    // Back to auto mid-scan: restart at channel 0 with frame_start.
    mode3 = 0; mode4 = 0;
    tick(1);
    check_eq("modechg.ch", ch3, 0);
    check_eq("modechg.fs", fs3, 1);
    tick(2);

    // en low with ready high: valid drops, y holds.
    en4 = 0;
    tick(1);
    check_eq("en0.valid", v4, 0);
    check_eq("en0.hold_y", y4, 32'h33);
    en4 = 1;
    tick(3);

    // Async reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst.y", {y4, y3}, 16'h0);
    check_eq("arst.flags", {v4, fs4, ch4, v3, fs3, ch3}, 8'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("arst.restart_ch", ch4, 0);
    check_eq("arst.restart_fs", fs4, 1);
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
